// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
// ID->EX pipeline register of the ARM core. Holds the two register-file
// operands, the decoded control word and the NZCV flags for the EX stage.
// A hazard stall (freeze) holds the contents. A taken branch (flush) or an
// invalid / illegal decode loads a bubble, which zeroes every field.
// Optional feature macro: FORWARDING_EN adds src1/src2 index registers for
// the EX forwarding unit. When it is undefined, those ports and flops are
// absent.
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int WordLen   = 32,
  parameter int WordCount = 16,
  localparam int RW       = $clog2(WordCount)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               flush,
  input  logic               validIn,
  input  logic [WordLen-1:0] pcIn,
  input  logic [WordLen-1:0] val1In,
  input  logic [WordLen-1:0] valRmIn,
  input  logic [3:0]         exeCmdIn,
  input  logic               memReadIn,
  input  logic               memWriteIn,
  input  logic               wbEnIn,
  input  logic               branchIn,
  input  logic               sUpdateIn,
  input  logic               immIn,
  input  logic [11:0]        shiftOpIn,
  input  logic [23:0]        imm24In,
  input  logic [RW-1:0]      destIn,
  input  logic [3:0]         statusIn,
`ifdef FORWARDING_EN
  input  logic [RW-1:0]      src1In,
  input  logic [RW-1:0]      src2In,
  output logic [RW-1:0]      src1Out,
  output logic [RW-1:0]      src2Out,
`endif
  output logic               validOut,
  output logic [WordLen-1:0] pcOut,
  output logic [WordLen-1:0] val1Out,
  output logic [WordLen-1:0] valRmOut,
  output logic [3:0]         exeCmdOut,
  output logic               memReadOut,
  output logic               memWriteOut,
  output logic               wbEnOut,
  output logic               branchOut,
  output logic               sUpdateOut,
  output logic               immOut,
  output logic [11:0]        shiftOpOut,
  output logic [23:0]        imm24Out,
  output logic [RW-1:0]      destOut,
  output logic [3:0]         statusOut
);

  // The complete stage contents. A bubble is simply the all-zero value, so
  // the control bits can never be 1 while valid is 0.
  typedef struct packed {
    logic               valid;
    logic [WordLen-1:0] pc;
    logic [WordLen-1:0] val1;
    logic [WordLen-1:0] val_rm;
    logic [3:0]         exe_cmd;
    logic               mem_read;
    logic               mem_write;
    logic               wb_en;
    logic               branch;
    logic               s_update;
    logic               imm;
    logic [11:0]        shift_op;
    logic [23:0]        imm24;
    logic [RW-1:0]      dest;
    logic [3:0]         status;
`ifdef FORWARDING_EN
    logic [RW-1:0]      src1;
    logic [RW-1:0]      src2;
`endif
  } stage_t;

  stage_t stage_q;
  stage_t capture_d;
  stage_t stage_d;
  logic   illegal_decode;
  logic   load_bubble;

  // A load that is also a store cannot be executed. It is dropped as a bubble
  // rather than letting EX see a contradictory memory command.
  assign illegal_decode = memReadIn & memWriteIn;
  assign load_bubble    = ~validIn | illegal_decode;

  // Assemble the candidate capture word from the decode-stage inputs.
  always_comb begin
    capture_d           = '0;
    capture_d.valid     = 1'b1;
    capture_d.pc        = pcIn;
    capture_d.val1      = val1In;
    capture_d.val_rm    = valRmIn;
    capture_d.exe_cmd   = exeCmdIn;
    capture_d.mem_read  = memReadIn;
    capture_d.mem_write = memWriteIn;
    capture_d.wb_en     = wbEnIn;
    capture_d.branch    = branchIn;
    capture_d.s_update  = sUpdateIn;
    capture_d.imm       = immIn;
    capture_d.shift_op  = shiftOpIn;
    capture_d.imm24     = imm24In;
    capture_d.dest      = destIn;
    capture_d.status    = statusIn;
`ifdef FORWARDING_EN
    capture_d.src1      = src1In;
    capture_d.src2      = src2In;
`endif
  end

  // Next-state selection: flush beats freeze, and freeze beats capture.
  // A capture of an invalid or illegal decode becomes a bubble.
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (!freeze) begin
      if (load_bubble) begin
        stage_d = '0;
      end else begin
        stage_d = capture_d;
      end
    end
  end

  // The stage register itself. Reset clears it asynchronously, even mid-stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign validOut    = stage_q.valid;
  assign pcOut       = stage_q.pc;
  assign val1Out     = stage_q.val1;
  assign valRmOut    = stage_q.val_rm;
  assign exeCmdOut   = stage_q.exe_cmd;
  assign memReadOut  = stage_q.mem_read;
  assign memWriteOut = stage_q.mem_write;
  assign wbEnOut     = stage_q.wb_en;
  assign branchOut   = stage_q.branch;
  assign sUpdateOut  = stage_q.s_update;
  assign immOut      = stage_q.imm;
  assign shiftOpOut  = stage_q.shift_op;
  assign imm24Out    = stage_q.imm24;
  assign destOut     = stage_q.dest;
  assign statusOut   = stage_q.status;
`ifdef FORWARDING_EN
  assign src1Out     = stage_q.src1;
  assign src2Out     = stage_q.src2;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage_reg
// Self-checking bench for id_ex_stage_reg. It runs directed scenarios and
// then random traffic against a record-level reference model.
// Honours FORWARDING_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_id_ex_stage_reg;

  localparam int WL = 32;
  localparam int RW = 4;
`ifdef FORWARDING_EN
  localparam int REC_W = 1 + 3*WL + 4 + 6 + 12 + 24 + RW + 4 + 2*RW;
`else
  localparam int REC_W = 1 + 3*WL + 4 + 6 + 12 + 24 + RW + 4;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          freeze, flush, validIn;
  logic [WL-1:0] pcIn, val1In, valRmIn;
  logic [3:0]    exeCmdIn;
  logic          memReadIn, memWriteIn, wbEnIn, branchIn, sUpdateIn, immIn;
  logic [11:0]   shiftOpIn;
  logic [23:0]   imm24In;
  logic [RW-1:0] destIn;
  logic [3:0]    statusIn;
  logic          validOut;
  logic [WL-1:0] pcOut, val1Out, valRmOut;
  logic [3:0]    exeCmdOut;
  logic          memReadOut, memWriteOut, wbEnOut, branchOut, sUpdateOut, immOut;
  logic [11:0]   shiftOpOut;
  logic [23:0]   imm24Out;
  logic [RW-1:0] destOut;
  logic [3:0]    statusOut;
`ifdef FORWARDING_EN
  logic [RW-1:0] src1In, src2In, src1Out, src2Out;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [REC_W-1:0] expRec;
  logic [REC_W-1:0] savedRec;

  id_ex_stage_reg dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .validIn(validIn),
    .pcIn(pcIn), .val1In(val1In), .valRmIn(valRmIn), .exeCmdIn(exeCmdIn),
    .memReadIn(memReadIn), .memWriteIn(memWriteIn), .wbEnIn(wbEnIn),
    .branchIn(branchIn), .sUpdateIn(sUpdateIn), .immIn(immIn),
    .shiftOpIn(shiftOpIn), .imm24In(imm24In), .destIn(destIn), .statusIn(statusIn),
`ifdef FORWARDING_EN
    .src1In(src1In), .src2In(src2In), .src1Out(src1Out), .src2Out(src2Out),
`endif
    .validOut(validOut), .pcOut(pcOut), .val1Out(val1Out), .valRmOut(valRmOut),
    .exeCmdOut(exeCmdOut), .memReadOut(memReadOut), .memWriteOut(memWriteOut),
    .wbEnOut(wbEnOut), .branchOut(branchOut), .sUpdateOut(sUpdateOut),
    .immOut(immOut), .shiftOpOut(shiftOpOut), .imm24Out(imm24Out),
    .destOut(destOut), .statusOut(statusOut)
  );

  always #5 clk = ~clk;

  // Everything the DUT currently presents, as one record.
  function automatic logic [REC_W-1:0] outRec();
`ifdef FORWARDING_EN
    return {validOut, pcOut, val1Out, valRmOut, exeCmdOut, memReadOut, memWriteOut,
            wbEnOut, branchOut, sUpdateOut, immOut, shiftOpOut, imm24Out, destOut,
            statusOut, src1Out, src2Out};
`else
    return {validOut, pcOut, val1Out, valRmOut, exeCmdOut, memReadOut, memWriteOut,
            wbEnOut, branchOut, sUpdateOut, immOut, shiftOpOut, imm24Out, destOut,
            statusOut};
`endif
  endfunction

  // The record that a clean capture of the present inputs should produce.
  function automatic logic [REC_W-1:0] inRec();
`ifdef FORWARDING_EN
    return {1'b1, pcIn, val1In, valRmIn, exeCmdIn, memReadIn, memWriteIn,
            wbEnIn, branchIn, sUpdateIn, immIn, shiftOpIn, imm24In, destIn,
            statusIn, src1In, src2In};
`else
    return {1'b1, pcIn, val1In, valRmIn, exeCmdIn, memReadIn, memWriteIn,
            wbEnIn, branchIn, sUpdateIn, immIn, shiftOpIn, imm24In, destIn,
            statusIn};
`endif
  endfunction

  // Reference behaviour at a rising edge: reset, then flush, then freeze,
  // then capture. A capture of an invalid or load+store decode is a bubble.
  task automatic modelEdge();
    if (rst || flush)                          expRec = '0;
    else if (freeze)                           expRec = expRec;
    else if (!validIn || (memReadIn && memWriteIn)) expRec = '0;
    else                                       expRec = inRec();
  endtask

  task automatic checkOutput(input string tag, input logic [REC_W-1:0] obs,
                             input logic [REC_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clearInputs();
    freeze = 0; flush = 0; validIn = 0; pcIn = '0; val1In = '0; valRmIn = '0;
    exeCmdIn = '0; memReadIn = 0; memWriteIn = 0; wbEnIn = 0; branchIn = 0;
    sUpdateIn = 0; immIn = 0; shiftOpIn = '0; imm24In = '0; destIn = '0; statusIn = '0;
`ifdef FORWARDING_EN
    src1In = '0; src2In = '0;
`endif
  endtask

  task automatic randomInputs();
    freeze     = ($urandom_range(3) == 0);
    flush      = ($urandom_range(7) == 0);
    validIn    = ($urandom_range(7) != 0);
    pcIn       = $urandom;
    val1In     = $urandom;
    valRmIn    = $urandom;
    exeCmdIn   = 4'($urandom_range(15));
    memReadIn  = ($urandom_range(3) == 0);
    memWriteIn = ($urandom_range(3) == 0);
    wbEnIn     = 1'($urandom_range(1));
    branchIn   = 1'($urandom_range(1));
    sUpdateIn  = 1'($urandom_range(1));
    immIn      = 1'($urandom_range(1));
    shiftOpIn  = 12'($urandom_range(4095));
    imm24In    = 24'($urandom);
    destIn     = 4'($urandom_range(15));
    statusIn   = 4'($urandom_range(15));
`ifdef FORWARDING_EN
    src1In     = 4'($urandom_range(15));
    src2In     = 4'($urandom_range(15));
`endif
  endtask

  // One clock: let the edge happen, update the model, settle past the edge.
  task automatic applyStimulus();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  initial begin
    clearInputs();
    rst = 1;
    expRec = '0;
    #1;
    checkOutput("reset_state", outRec(), '0);
    repeat (2) applyStimulus();
    @(negedge clk) rst = 0;

    // Basic capture with distinctive operand values.
    validIn = 1; val1In = 32'h0000_0005; valRmIn = 32'hFFFF_FFFF; wbEnIn = 1; destIn = 3;
    pcIn = 32'h0000_0104; exeCmdIn = 4'h4; statusIn = 4'hA;
    applyStimulus();
    checkOutput("capture_rec", outRec(), expRec);
    checkOutput("capture_val1", REC_W'(val1Out), REC_W'(32'h5));
    checkOutput("capture_valrm", REC_W'(valRmOut), REC_W'(32'hFFFF_FFFF));
    checkOutput("capture_ctl", REC_W'({validOut, wbEnOut, destOut}), REC_W'(6'b11_0011));

    // Asynchronous reset in the middle of a cycle clears everything at once.
    @(negedge clk);
    #2 rst = 1;
    #1 checkOutput("async_reset", outRec(), '0);
    expRec = '0;
    applyStimulus();
    checkOutput("reset_held", outRec(), '0);
    @(negedge clk) rst = 0;

    // Freeze holds A for three cycles while the inputs move to B.
    validIn = 1; pcIn = 32'h1111_0000; val1In = 32'hAAAA_0001; valRmIn = 32'hAAAA_0002;
    memReadIn = 1; wbEnIn = 1; destIn = 4'd9; shiftOpIn = 12'h123; imm24In = 24'hABCDEF;
    applyStimulus();
    savedRec = inRec();
    checkOutput("freeze_captureA", outRec(), savedRec);
    @(negedge clk);
    freeze = 1; pcIn = 32'h2222_0000; val1In = 32'hBBBB_0001; valRmIn = 32'hBBBB_0002;
    memReadIn = 0; memWriteIn = 1; destIn = 4'd2;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      checkOutput($sformatf("freeze_hold%0d", i), outRec(), savedRec);
    end
    @(negedge clk) freeze = 0;
    applyStimulus();
    checkOutput("freeze_releaseB", outRec(), inRec());

    // Reset during a stall still clears the stage.
    @(negedge clk) freeze = 1;
    #1 rst = 1;
    #1 checkOutput("reset_in_freeze", outRec(), '0);
    expRec = '0;
    @(negedge clk) begin rst = 0; freeze = 0; end
    applyStimulus();
    checkOutput("recapture", outRec(), expRec);

    // Flush wins over a simultaneous freeze.
    @(negedge clk) begin flush = 1; freeze = 1; memWriteIn = 1; memReadIn = 0; end
    applyStimulus();
    checkOutput("flush_freeze_rec", outRec(), '0);
    checkOutput("flush_freeze_bits", REC_W'({validOut, memWriteOut, val1Out}), '0);

    // A load+store decode is captured as a bubble.
    @(negedge clk) begin flush = 0; freeze = 0; validIn = 1; memReadIn = 1; memWriteIn = 1; end
    applyStimulus();
    checkOutput("illegal_decode", outRec(), '0);

    // validIn low is captured as a bubble.
    @(negedge clk) begin memWriteIn = 0; validIn = 0; end
    applyStimulus();
    checkOutput("invalid_bubble", outRec(), '0);

    // Destination 0 with write enable passes through unchanged.
    @(negedge clk) begin validIn = 1; destIn = 0; wbEnIn = 1; memReadIn = 0; end
    applyStimulus();
    checkOutput("dest_zero", REC_W'({validOut, wbEnOut, destOut}), REC_W'(6'b11_0000));

`ifdef FORWARDING_EN
    // Source indices follow the same capture and flush rules.
    @(negedge clk) begin src1In = 4'd7; src2In = 4'd12; end
    applyStimulus();
    checkOutput("src_capture", REC_W'({src1Out, src2Out}), REC_W'(8'h7C));
    @(negedge clk) flush = 1;
    applyStimulus();
    checkOutput("src_flush", REC_W'({src1Out, src2Out}), '0);
    @(negedge clk) flush = 0;
`endif

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk) randomInputs();
      applyStimulus();
      checkOutput($sformatf("random%0d", n), outRec(), expRec);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
